bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq_if.sv | 28 ++
 rtl/bin_to_bcd_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Request/response bundle of the sequential binary-to-BCD converter.
// The master issues i_start/i_bin and observes o_busy/o_done/o_bcd/o_ovf.
interface bin_to_bcd_seq_if;
  logic        i_start;
  logic [13:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_bcd;
  logic        o_ovf;

  modport master (
    output i_start,
    output i_bin,
    input  o_busy,
    input  o_done,
    input  o_bcd,
    input  o_ovf
  );

  modport slave (
    input  i_start,
    input  i_bin,
    output o_busy,
    output o_done,
    output o_bcd,
    output o_ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (shift-and-add-3, 14 iterations).
// Optional saturation to 9999 with overflow flag is compiled in by defining BIN2BCD_SAT_EN.
module bin_to_bcd_seq (
  input  logic             i_clk,
  input  logic             i_rst,
  bin_to_bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] sr_q,    sr_d;
  logic [15:0] acc_q,   acc_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] bcd_q,   bcd_d;
  logic        done_q,  done_d;
  logic [15:0] adj_s;
`ifdef BIN2BCD_SAT_EN
  logic        sat_q,   sat_d;
  logic        ovf_q,   ovf_d;
`endif

  // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
    logic [15:0] r;
    r = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    adj_s   = dabble_adjust(acc_q);
`ifdef BIN2BCD_SAT_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_CONV;
          sr_d    = bus.i_bin;
          acc_d   = 16'h0000;
          cnt_d   = 4'd14;
`ifdef BIN2BCD_SAT_EN
          sat_d   = (bus.i_bin > 14'd9999);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CONV: begin
        // The bit shifted out of the thousands nibble is the ten-thousands carry; dropping it wraps mod 10000.
        acc_d = {adj_s[14:0], sr_q[13]};
        sr_d  = {sr_q[12:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONV;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef BIN2BCD_SAT_EN
        if (sat_q) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = acc_q;
          ovf_d = 1'b0;
        end
`else
        bcd_d   = acc_q;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any pending start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sr_q    <= 14'h0000;
      acc_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      bcd_q   <= 16'h0000;
      done_q  <= 1'b0;
`ifdef BIN2BCD_SAT_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
`ifdef BIN2BCD_SAT_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_busy = (state_q != ST_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_bcd  = bcd_q;
`ifdef BIN2BCD_SAT_EN
  assign bus.o_ovf  = ovf_q;
`else
  assign bus.o_ovf  = 1'b0;
`endif

endmodule
